sliding_tile_sequencer: RTL and testbench

Move sequencer for the 3x3 sliding-tile board. It buffers space-move commands from a host in a small FIFO and issues them to the board one at a time as a one-cycle `board_move` strobe plus `board_dir`. It tracks the space location, drops illegal edge moves, counts issued moves, and stops when the board reports solved or a move limit is reached. It sits between the host/testbench command source and the board datapath; the board updates only on `board_move`.

---
 rtl/sliding_tile_sequencer_if.sv | 19 +
 rtl/sliding_tile_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sliding_tile_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sliding_tile_sequencer_if.sv
// Command and board channels of the sliding-tile move sequencer.
interface sliding_tile_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic [1:0] board_dir;
  logic       board_move;
  logic       board_solved;

  modport master (
    output cmd_valid, cmd_dir, board_solved,
    input  cmd_ready, board_dir, board_move
  );

  modport slave (
    input  cmd_valid, cmd_dir, board_solved,
    output cmd_ready, board_dir, board_move
  );
endinterface

// File: rtl/sliding_tile_sequencer.sv
// Move sequencer for the 3x3 sliding-tile board: buffers host space-move commands,
// drops illegal edge moves and strobes legal ones into the board one at a time.
module sliding_tile_sequencer #(
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 10,
  parameter int MAX_MOVES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  sliding_tile_sequencer_if.slave bus,
  input  logic                    start,
  input  logic                    abort,
  output logic [3:0]              space_loc,
  output logic [CNT_W-1:0]        move_count,
  output logic                    rejected,
  output logic [2:0]              state
);
  localparam int               AW        = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_FILL = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] MAX_CNT   = MAX_MOVES[CNT_W-1:0];
  localparam logic [3:0]       LOC_RESET = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_CHECK  = 3'd2,
    S_SOLVED = 3'd3,
    S_LIMIT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    D_LEFT  = 2'b00,
    D_RIGHT = 2'b01,
    D_UP    = 2'b10,
    D_DOWN  = 2'b11
  } dir_e;

  state_e          cur_state, nxt_state;
  dir_e            fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fill;
  logic            full, empty, push, pop;
  logic            issue, reject, flush, clear_cnt;
  dir_e            head_dir;
  logic            head_legal;
  logic            move_q;
  dir_e            dir_q;

  function automatic logic is_legal(input dir_e dir, input logic [3:0] loc);
    case (dir)
      D_LEFT:  return loc[1:0] != 2'd0;
      D_RIGHT: return loc[1:0] <  2'd2;
      D_UP:    return loc[3:2] != 2'd0;
      default: return loc[3:2] <  2'd2;
    endcase
  endfunction

  function automatic logic [3:0] step_loc(input dir_e dir, input logic [3:0] loc);
    logic [1:0] row;
    logic [1:0] col;
    row = loc[3:2];
    col = loc[1:0];
    case (dir)
      D_LEFT:  col = col - 2'd1;
      D_RIGHT: col = col + 2'd1;
      D_UP:    row = row - 2'd1;
      default: row = row + 2'd1;
    endcase
    return {row, col};
  endfunction

  assign full       = (fill == FULL_FILL);
  assign empty      = (fill == '0);
  assign head_dir   = fifo_mem[rd_ptr];
  assign head_legal = is_legal(head_dir, space_loc);

  // Ready ignores a same-cycle pop so it never depends on the sequencer's decision.
  assign bus.cmd_ready  = !full && (cur_state != S_SOLVED) && (cur_state != S_LIMIT);
  assign push           = bus.cmd_valid && bus.cmd_ready && !flush;
  assign bus.board_move = move_q;
  assign bus.board_dir  = dir_q;
  assign state          = cur_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    nxt_state = cur_state;
    pop       = 1'b0;
    issue     = 1'b0;
    reject    = 1'b0;
    flush     = 1'b0;
    clear_cnt = 1'b0;
    if (abort) begin
      nxt_state = S_IDLE;
      flush     = 1'b1;
    end else begin
      case (cur_state)
        S_IDLE: if (start) nxt_state = S_ISSUE;
        S_ISSUE: begin
          if (!empty) begin
            pop = 1'b1;
            if (head_legal) begin
              issue     = 1'b1;
              nxt_state = S_CHECK;
            end else begin
              reject = 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (bus.board_solved) begin
            nxt_state = S_SOLVED;
            flush     = 1'b1;
          end else if (move_count == MAX_CNT) begin
            nxt_state = S_LIMIT;
            flush     = 1'b1;
          end else begin
            nxt_state = S_ISSUE;
          end
        end
        S_SOLVED, S_LIMIT: begin
          if (start) begin
            nxt_state = S_IDLE;
            clear_cnt = 1'b1;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // NOTE: the command storage is not reset; the pointers and fill level
  // alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dir_e'(bus.cmd_dir);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      move_q     <= 1'b0;
      dir_q      <= D_LEFT;
      rejected   <= 1'b0;
      space_loc  <= LOC_RESET;
      move_count <= '0;
    end else begin
      move_q   <= issue;
      rejected <= reject;
      if (issue) begin
        dir_q      <= head_dir;
        space_loc  <= step_loc(head_dir, space_loc);
        move_count <= move_count + CNT_W'(1);
      end
      if (clear_cnt) move_count <= '0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fill <= fill + 1'b1;
          2'b01:   fill <= fill - 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sliding_tile_sequencer.sv
// Self-checking bench for sliding_tile_sequencer: command tables plus hand-written
// corner sequences, with issued moves compared against a scoreboard queue.
module tb_sliding_tile_sequencer;
  localparam logic [1:0] L = 2'b00, R = 2'b01, U = 2'b10, D = 2'b11;

  typedef struct {
    logic [1:0] dir;
    logic       legal;
    logic [3:0] loc;   // space location once this command has been handled
  } vec_t;

  typedef struct {
    logic [1:0] dir;
    logic [3:0] loc;
    logic [9:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_m, abort_m, start_l, abort_l;
  logic [3:0] loc_m, loc_l;
  logic [9:0] cnt_m, cnt_l;
  logic       rej_m, rej_l;
  logic [2:0] st_m, st_l;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bm_count = 0;
  int solve_base = 0;
  logic solve_armed = 1'b0;

  vec_t vecs [8];
  exp_t sb_main [$];
  exp_t sb_lim  [$];
  int   mv_cyc  [$];
  int   rej_cyc [$];
  logic [9:0] exp_cnt;

  sliding_tile_sequencer_if bus_m ();
  sliding_tile_sequencer_if bus_l ();

  sliding_tile_sequencer dut (
    .clk(clk), .reset(rst), .bus(bus_m), .start(start_m), .abort(abort_m),
    .space_loc(loc_m), .move_count(cnt_m), .rejected(rej_m), .state(st_m)
  );

  sliding_tile_sequencer #(.MAX_MOVES(3)) dut_lim (
    .clk(clk), .reset(rst), .bus(bus_l), .start(start_l), .abort(abort_l),
    .space_loc(loc_l), .move_count(cnt_l), .rejected(rej_l), .state(st_l)
  );

  always #5 clk = ~clk;

  // Board model: its solved flag already reflects the strobed move while the
  // sequencer sits in CHECK; it reports solved once two moves have been made.
  always @(posedge clk) if (bus_m.board_move) bm_count <= bm_count + 1;
  assign bus_m.board_solved = solve_armed &&
                              ((bm_count - solve_base + (bus_m.board_move ? 1 : 0)) >= 2);
  assign bus_l.board_solved = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (bus_m.board_move) begin
        mv_cyc.push_back(cyc);
        if (sb_main.size() == 0) begin
          check("unexpected_move", 32'(bus_m.board_move), 32'(0));
        end else begin
          exp_t e;
          e = sb_main.pop_front();
          check("move_dir", 32'(bus_m.board_dir), 32'(e.dir));
          check("move_loc", 32'(loc_m), 32'(e.loc));
          check("move_cnt", 32'(cnt_m), 32'(e.cnt));
        end
      end
      if (rej_m) rej_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_l.board_move) begin
      if (sb_lim.size() == 0) begin
        check("lim_unexpected_move", 32'(bus_l.board_move), 32'(0));
      end else begin
        exp_t e;
        e = sb_lim.pop_front();
        check("lim_move_dir", 32'(bus_l.board_dir), 32'(e.dir));
        check("lim_move_loc", 32'(loc_l), 32'(e.loc));
        check("lim_move_cnt", 32'(cnt_l), 32'(e.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_main(input logic [1:0] dir);
    bus_m.cmd_valid = 1'b1;
    bus_m.cmd_dir   = dir;
    tick();
    bus_m.cmd_valid = 1'b0;
  endtask

  task automatic enq_lim(input logic [1:0] dir);
    bus_l.cmd_valid = 1'b1;
    bus_l.cmd_dir   = dir;
    tick();
    bus_l.cmd_valid = 1'b0;
  endtask

  task automatic expect_main(input logic [1:0] dir, input logic [3:0] loc);
    exp_t e;
    exp_cnt = exp_cnt + 10'd1;
    e.dir = dir; e.loc = loc; e.cnt = exp_cnt;
    sb_main.push_back(e);
  endtask

  task automatic pulse_start();
    start_m = 1'b1; tick(); start_m = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_m = 1'b1; tick(); abort_m = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (sb_main.size() == 0) break;
      tick();
    end
    check(name, 32'(sb_main.size()), 32'(0));
  endtask

  // Enqueue table entries in IDLE, start, and compare moves, rejections and spacing.
  task automatic run_table(input int first, input int n);
    int nrej;
    nrej = 0;
    mv_cyc.delete();
    rej_cyc.delete();
    for (int i = first; i < first + n; i++) begin
      enq_main(vecs[i].dir);
      if (vecs[i].legal) expect_main(vecs[i].dir, vecs[i].loc);
      else nrej++;
    end
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      if (sb_main.size() == 0 && rej_cyc.size() == nrej) break;
      tick();
    end
    repeat (4) tick();
    check("tbl_drain", 32'(sb_main.size()), 32'(0));
    check("tbl_rejects", 32'(rej_cyc.size()), 32'(nrej));
    for (int k = 1; k < mv_cyc.size(); k++)
      check("tbl_move_spacing", 32'(mv_cyc[k] - mv_cyc[k-1]), 32'(2));
    for (int k = 1; k < rej_cyc.size(); k++)
      check("tbl_reject_spacing", 32'(rej_cyc[k] - rej_cyc[k-1]), 32'(1));
    check("tbl_loc", 32'(loc_m), 32'(vecs[first+n-1].loc));
    check("tbl_cnt", 32'(cnt_m), 32'(exp_cnt));
    check("tbl_state", 32'(st_m), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{R, 1'b0, 4'b1010};
    vecs[1] = '{D, 1'b0, 4'b1010};
    vecs[2] = '{L, 1'b1, 4'b1001};
    vecs[3] = '{L, 1'b1, 4'b1000};
    vecs[4] = '{U, 1'b1, 4'b0100};
    vecs[5] = '{R, 1'b1, 4'b0101};
    vecs[6] = '{D, 1'b1, 4'b1001};
    vecs[7] = '{U, 1'b1, 4'b0101};

    rst = 1'b1;
    start_m = 1'b0; abort_m = 1'b0; start_l = 1'b0; abort_l = 1'b0;
    bus_m.cmd_valid = 1'b0; bus_m.cmd_dir = 2'b00;
    bus_l.cmd_valid = 1'b0; bus_l.cmd_dir = 2'b00;
    exp_cnt = 10'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset values.
    check("rst_state", 32'(st_m), 32'(0));
    check("rst_loc", 32'(loc_m), 32'(4'b1010));
    check("rst_cnt", 32'(cnt_m), 32'(0));
    check("rst_move", 32'(bus_m.board_move), 32'(0));
    check("rst_dir", 32'(bus_m.board_dir), 32'(0));
    check("rst_ready", 32'(bus_m.cmd_ready), 32'(1));
    check("rst_rejected", 32'(rej_m), 32'(0));
    check("rst_lim_state", 32'(st_l), 32'(0));

    // Illegal edge moves, then the legal sequence from IDLE.
    run_table(0, 2);
    pulse_abort();
    check("abort_idle", 32'(st_m), 32'(0));
    check("abort_keeps_loc", 32'(loc_m), 32'(4'b1010));
    run_table(2, 4);

    // Enqueue-to-move latency in ISSUE with an empty FIFO, then an immediate reversal.
    bus_m.cmd_valid = 1'b1;
    bus_m.cmd_dir   = vecs[6].dir;
    expect_main(vecs[6].dir, vecs[6].loc);
    tick();
    bus_m.cmd_valid = 1'b0;
    check("lat_cycle1_no_move", 32'(bus_m.board_move), 32'(0));
    tick();
    check("lat_cycle2_move", 32'(bus_m.board_move), 32'(1));
    check("lat_loc", 32'(loc_m), 32'(vecs[6].loc));
    enq_main(vecs[7].dir);
    expect_main(vecs[7].dir, vecs[7].loc);
    wait_drain("reverse_drain");
    check("reverse_loc", 32'(loc_m), 32'(4'b0101));
    check("reverse_cnt", 32'(cnt_m), 32'(6));

    // Board reports solved after the second issued move with three queued.
    pulse_abort();
    solve_base  = bm_count;
    solve_armed = 1'b1;
    enq_main(L); expect_main(L, 4'b0100);
    enq_main(R); expect_main(R, 4'b0101);
    enq_main(D);
    pulse_start();
    for (int k = 0; k < 30; k++) begin
      if (st_m == 3'd3) break;
      tick();
    end
    repeat (4) tick();
    check("solved_state", 32'(st_m), 32'(3));
    check("solved_ready", 32'(bus_m.cmd_ready), 32'(0));
    check("solved_cnt", 32'(cnt_m), 32'(8));
    check("solved_drain", 32'(sb_main.size()), 32'(0));
    solve_armed = 1'b0;
    pulse_start();
    exp_cnt = 10'd0;
    check("solved_restart_state", 32'(st_m), 32'(0));
    check("solved_restart_cnt", 32'(cnt_m), 32'(0));
    check("solved_restart_loc", 32'(loc_m), 32'(4'b0101));
    check("solved_restart_ready", 32'(bus_m.cmd_ready), 32'(1));
    pulse_start();
    repeat (6) tick();
    check("solved_flushed_state", 32'(st_m), 32'(1));

    // Full FIFO, abort over start, and abort over a same-cycle enqueue.
    pulse_abort();
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(bus_m.cmd_ready), 32'(1));
      enq_main(2'(i));
    end
    bus_m.cmd_valid = 1'b1;
    bus_m.cmd_dir   = U;
    #1;
    check("full_refuse", 32'(bus_m.cmd_ready), 32'(0));
    abort_m = 1'b1;
    start_m = 1'b1;
    tick();
    abort_m = 1'b0;
    start_m = 1'b0;
    check("abort_start_state", 32'(st_m), 32'(0));
    check("abort_start_ready", 32'(bus_m.cmd_ready), 32'(1));
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
    bus_m.cmd_valid = 1'b0;
    pulse_start();
    repeat (6) tick();
    check("abort_flushed_state", 32'(st_m), 32'(1));
    check("abort_no_moves", 32'(cnt_m), 32'(0));

    // Move limit of 3 on the second instance.
    enq_lim(U); enq_lim(L); enq_lim(D); enq_lim(R);
    sb_lim.push_back('{U, 4'b0110, 10'd1});
    sb_lim.push_back('{L, 4'b0101, 10'd2});
    sb_lim.push_back('{D, 4'b1001, 10'd3});
    start_l = 1'b1; tick(); start_l = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (st_l == 3'd4) break;
      tick();
    end
    repeat (4) tick();
    check("lim_state", 32'(st_l), 32'(4));
    check("lim_cnt", 32'(cnt_l), 32'(3));
    check("lim_loc", 32'(loc_l), 32'(4'b1001));
    check("lim_ready", 32'(bus_l.cmd_ready), 32'(0));
    check("lim_drain", 32'(sb_lim.size()), 32'(0));
    start_l = 1'b1; tick(); start_l = 1'b0;
    check("lim_restart_cnt", 32'(cnt_l), 32'(0));
    start_l = 1'b1; tick(); start_l = 1'b0;
    repeat (6) tick();
    check("lim_flushed_state", 32'(st_l), 32'(1));

    // Asynchronous reset while a move strobe is out.
    bus_m.cmd_valid = 1'b1;
    bus_m.cmd_dir   = U;
    expect_main(U, 4'b0001);
    tick();
    bus_m.cmd_dir   = L;
    tick();
    bus_m.cmd_valid = 1'b0;
    check("pre_reset_move", 32'(bus_m.board_move), 32'(1));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_state", 32'(st_m), 32'(0));
    check("async_loc", 32'(loc_m), 32'(4'b1010));
    check("async_cnt", 32'(cnt_m), 32'(0));
    check("async_move", 32'(bus_m.board_move), 32'(0));
    check("async_ready", 32'(bus_m.cmd_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick();
    check("post_reset_state", 32'(st_m), 32'(0));
    check("post_reset_drain", 32'(sb_main.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
